// File: rtl/digit_serial_adder.sv
// Digit-serial adder/subtractor: adds WIDTH-bit operands DIGIT bits per clock through a
// registered carry, with a start/busy/done handshake and results held between operations.

module digit_serial_adder_digit #(
    parameter int DIGIT = 4
) (
    input  logic [DIGIT-1:0] i_a,
    input  logic [DIGIT-1:0] i_b,
    input  logic             i_c,
    output logic [DIGIT-1:0] o_d,
    output logic             o_c
);
    assign {o_c, o_d} = {1'b0, i_a} + {1'b0, i_b} + {{DIGIT{1'b0}}, i_c};
endmodule

module digit_serial_adder #(
    parameter int WIDTH = 16,
    parameter int DIGIT = 4
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_start,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic             i_cin,
    input  logic             i_sub,
    output logic             o_busy,
    output logic             o_done,
    output logic [WIDTH-1:0] o_sum,
    output logic             o_carry,
    output logic             o_overflow
);
    localparam int NDIG = WIDTH / DIGIT;
    localparam int CW   = (NDIG > 1) ? $clog2(NDIG) : 1;
    localparam logic [CW-1:0] LAST = CW'(NDIG - 1);

    generate
        if (DIGIT < 1 || DIGIT > WIDTH || (WIDTH % DIGIT) != 0) begin : g_bad_param
            $error("digit_serial_adder: DIGIT must be 1..WIDTH and divide WIDTH");
        end
    endgenerate

    typedef enum logic {IDLE, RUN} state_t;

    state_t           r_state, w_next;
    logic             w_accept, w_last;
    logic [WIDTH-1:0] r_a, r_b;
    logic             r_c;
    logic [CW-1:0]    r_cnt;
    logic             r_amsb, r_bmsb;
    logic [DIGIT-1:0] w_d;
    logic             w_cout;
    logic [WIDTH-1:0] w_res_next;
    logic             r_done, r_carry, r_ovf;
    logic [WIDTH-1:0] r_sum;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) r_state <= IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next   = r_state;
        w_accept = 1'b0;
        w_last   = 1'b0;
        unique case (r_state)
            IDLE: if (i_start) begin
                w_accept = 1'b1;
                w_next   = RUN;
            end
            RUN: if (r_cnt == LAST) begin
                w_last = 1'b1;
                w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    digit_serial_adder_digit #(.DIGIT(DIGIT)) u_digit (
        .i_a (r_a[DIGIT-1:0]),
        .i_b (r_b[DIGIT-1:0]),
        .i_c (r_c),
        .o_d (w_d),
        .o_c (w_cout)
    );

    // Subtraction is folded in at capture: B is inverted and the borrow-in becomes carry-in.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_a    <= '0;
            r_b    <= '0;
            r_c    <= 1'b0;
            r_cnt  <= '0;
            r_amsb <= 1'b0;
            r_bmsb <= 1'b0;
        end else if (w_accept) begin
            r_a    <= i_a;
            r_b    <= i_sub ? ~i_b : i_b;
            r_c    <= i_sub ? ~i_cin : i_cin;
            r_cnt  <= '0;
            r_amsb <= i_a[WIDTH-1];
            r_bmsb <= i_sub ? ~i_b[WIDTH-1] : i_b[WIDTH-1];
        end else if (r_state == RUN) begin
            r_a   <= r_a >> DIGIT;
            r_b   <= r_b >> DIGIT;
            r_c   <= w_cout;
            r_cnt <= r_cnt + CW'(1);
        end
    end

    // Earlier digits enter at the top and slide down, so the final digit lands in the MSBs.
    generate
        if (NDIG > 1) begin : g_acc
            logic [WIDTH-DIGIT-1:0] r_part;
            always_ff @(posedge i_clk or posedge i_rst) begin
                if (i_rst)                r_part <= '0;
                else if (r_state == RUN)  r_part <= w_res_next[WIDTH-1:DIGIT];
            end
            assign w_res_next = {w_d, r_part};
        end else begin : g_single
            assign w_res_next = w_d;
        end
    endgenerate

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_done  <= 1'b0;
            r_sum   <= '0;
            r_carry <= 1'b0;
            r_ovf   <= 1'b0;
        end else begin
            r_done <= w_last;
            if (w_last) begin
                r_sum   <= w_res_next;
                r_carry <= w_cout;
                r_ovf   <= (r_amsb == r_bmsb) && (w_res_next[WIDTH-1] != r_amsb);
            end
        end
    end

    assign o_busy     = (r_state == RUN);
    assign o_done     = r_done;
    assign o_sum      = r_sum;
    assign o_carry    = r_carry;
    assign o_overflow = r_ovf;
endmodule

// File: tb/tb_digit_serial_adder.sv
// Bench for digit_serial_adder: three instances (DIGIT=4, 1, 16) share stimulus and are
// checked against an arithmetic reference model for result, latency and handshake.

module tb_digit_serial_adder;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [15:0] a = '0, b = '0;
    logic        cin = 1'b0, sub = 1'b0;

    logic [2:0]  busy, done, carry, ovf;
    logic [15:0] sum [3];

    int          vectors = 0;
    int          errors  = 0;
    logic [17:0] last [3];
    logic [2:0]  valid = '0;

    always #5 clk = ~clk;

    digit_serial_adder #(.WIDTH(16), .DIGIT(4)) u_d4 (
        .i_clk(clk), .i_rst(rst), .i_start(start), .i_a(a), .i_b(b), .i_cin(cin), .i_sub(sub),
        .o_busy(busy[0]), .o_done(done[0]), .o_sum(sum[0]), .o_carry(carry[0]), .o_overflow(ovf[0]));
    digit_serial_adder #(.WIDTH(16), .DIGIT(1)) u_d1 (
        .i_clk(clk), .i_rst(rst), .i_start(start), .i_a(a), .i_b(b), .i_cin(cin), .i_sub(sub),
        .o_busy(busy[1]), .o_done(done[1]), .o_sum(sum[1]), .o_carry(carry[1]), .o_overflow(ovf[1]));
    digit_serial_adder #(.WIDTH(16), .DIGIT(16)) u_d16 (
        .i_clk(clk), .i_rst(rst), .i_start(start), .i_a(a), .i_b(b), .i_cin(cin), .i_sub(sub),
        .o_busy(busy[2]), .o_done(done[2]), .o_sum(sum[2]), .o_carry(carry[2]), .o_overflow(ovf[2]));

    function automatic int nd(input int i);
        case (i)
            0:       return 4;
            1:       return 16;
            default: return 1;
        endcase
    endfunction

    function automatic logic [17:0] obs(input int i);
        return {carry[i], ovf[i], sum[i]};
    endfunction

    // {carry, overflow, sum} from plain signed/unsigned arithmetic
    function automatic logic [17:0] model(input logic [15:0] x, input logic [15:0] y,
                                          input logic c, input logic s);
        logic [16:0] f;
        logic        co, v;
        if (!s) begin
            f  = {1'b0, x} + {1'b0, y} + {16'd0, c};
            co = f[16];
            v  = (x[15] == y[15]) && (f[15] != x[15]);
        end else begin
            f  = {1'b0, x} - {1'b0, y} - {16'd0, c};
            co = ~f[16];
            v  = (x[15] != y[15]) && (f[15] != x[15]);
        end
        return {co, v, f[15:0]};
    endfunction

    task automatic drain(input int n);
        start = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    task automatic run_op(input logic [15:0] ta, input logic [15:0] tb_, input logic tc, input logic ts);
        logic [17:0] exp;
        exp = model(ta, tb_, tc, ts);
        @(negedge clk);
        a = ta; b = tb_; cin = tc; sub = ts; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        a = 16'($urandom); b = 16'($urandom); cin = 1'($urandom); sub = 1'($urandom);
        for (int i = 0; i < 3; i++) begin
            vectors++;
            if (busy[i] !== 1'b1 || done[i] !== 1'b0) begin
                errors++;
                $display("FAIL accept inst%0d busy=%b done=%b want busy=1 done=0", i, busy[i], done[i]);
            end
        end
        for (int k = 1; k <= 17; k++) begin
            @(negedge clk);
            for (int i = 0; i < 3; i++) begin
                if (k < nd(i)) begin
                    vectors++;
                    if (busy[i] !== 1'b1 || done[i] !== 1'b0 || (valid[i] && obs(i) !== last[i])) begin
                        errors++;
                        $display("FAIL running inst%0d k=%0d busy=%b done=%b res=%h want busy=1 done=0 res=%h",
                                 i, k, busy[i], done[i], obs(i), last[i]);
                    end
                end else if (k == nd(i)) begin
                    vectors++;
                    if (busy[i] !== 1'b0 || done[i] !== 1'b1 || obs(i) !== exp) begin
                        errors++;
                        $display("FAIL result inst%0d a=%h b=%h cin=%b sub=%b busy=%b done=%b res=%h want done=1 res=%h",
                                 i, ta, tb_, tc, ts, busy[i], done[i], obs(i), exp);
                    end
                end else if (k == nd(i) + 1) begin
                    vectors++;
                    if (busy[i] !== 1'b0 || done[i] !== 1'b0 || obs(i) !== exp) begin
                        errors++;
                        $display("FAIL hold inst%0d busy=%b done=%b res=%h want busy=0 done=0 res=%h",
                                 i, busy[i], done[i], obs(i), exp);
                    end
                end
            end
        end
        for (int i = 0; i < 3; i++) begin
            last[i] = exp;
            valid[i] = 1'b1;
        end
    endtask

    task automatic test_reset;
        for (int i = 0; i < 3; i++) begin
            vectors++;
            if ({busy[i], done[i], obs(i)} !== 20'd0) begin
                errors++;
                $display("FAIL reset inst%0d outputs=%h want 0", i, {busy[i], done[i], obs(i)});
            end
        end
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            last[i] = '0;
            valid[i] = 1'b1;
        end
    endtask

    task automatic test_directed;
        run_op(16'hFFFF, 16'h0001, 1'b0, 1'b0);
        run_op(16'h7FFF, 16'h0001, 1'b0, 1'b0);
        run_op(16'h1234, 16'h4321, 1'b1, 1'b0);
        run_op(16'h0005, 16'h0007, 1'b0, 1'b1);
        run_op(16'h8000, 16'h0001, 1'b0, 1'b1);
        run_op(16'h0000, 16'h0000, 1'b1, 1'b1);
        run_op(16'hFFFF, 16'hFFFF, 1'b1, 1'b0);
    endtask

    task automatic test_random;
        for (int n = 0; n < 25; n++)
            run_op(16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom));
    endtask

    task automatic test_reset_mid;
        @(negedge clk);
        a = 16'hABCD; b = 16'h1357; cin = 1'b1; sub = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        #1 rst = 1'b1;
        #1;
        for (int i = 0; i < 3; i++) begin
            vectors++;
            if ({busy[i], done[i], obs(i)} !== 20'd0) begin
                errors++;
                $display("FAIL reset_mid inst%0d outputs=%h want 0", i, {busy[i], done[i], obs(i)});
            end
        end
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            vectors++;
            if (done !== 3'b000 || busy !== 3'b000) begin
                errors++;
                $display("FAIL no_done_after_reset k=%0d done=%b busy=%b want 0", k, done, busy);
            end
        end
        for (int i = 0; i < 3; i++) begin
            last[i] = '0;
            valid[i] = 1'b1;
        end
        run_op(16'h4000, 16'h4000, 1'b0, 1'b0);
    endtask

    task automatic test_ignore_start;
        logic [17:0] exp;
        exp = model(16'h0F0F, 16'h00F1, 1'b0, 1'b0);
        @(negedge clk);
        a = 16'h0F0F; b = 16'h00F1; cin = 1'b0; sub = 1'b0; start = 1'b1;
        @(negedge clk);
        a = 16'hFFFF; b = 16'h8000; cin = 1'b1; sub = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            vectors++;
            if (k < 4) begin
                if (busy[0] !== 1'b1 || done[0] !== 1'b0) begin
                    errors++;
                    $display("FAIL ignore_run k=%0d busy=%b done=%b want busy=1 done=0", k, busy[0], done[0]);
                end
            end else if (k == 4) begin
                if (done[0] !== 1'b1 || obs(0) !== exp) begin
                    errors++;
                    $display("FAIL ignore_result done=%b res=%h want done=1 res=%h", done[0], obs(0), exp);
                end
            end else if (busy[0] !== 1'b0 || done[0] !== 1'b0) begin
                errors++;
                $display("FAIL ignore_after busy=%b done=%b want 0 0", busy[0], done[0]);
            end
            if (k == 3) start = 1'b0;
        end
        last[0] = exp;
        valid[2:1] = 2'b00;
        drain(20);
    endtask

    task automatic test_back_to_back;
        logic [17:0] e1, e2;
        e1 = model(16'h1111, 16'h2222, 1'b0, 1'b0);
        e2 = model(16'h0100, 16'h0200, 1'b1, 1'b1);
        @(negedge clk);
        a = 16'h1111; b = 16'h2222; cin = 1'b0; sub = 1'b0; start = 1'b1;
        @(negedge clk);
        a = 16'h0100; b = 16'h0200; cin = 1'b1; sub = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            vectors++;
            case (k)
                4: if (done[0] !== 1'b1 || busy[0] !== 1'b0 || obs(0) !== e1) begin
                    errors++;
                    $display("FAIL b2b_first done=%b busy=%b res=%h want 1 0 %h", done[0], busy[0], obs(0), e1);
                end
                5: if (done[0] !== 1'b0 || busy[0] !== 1'b1 || obs(0) !== e1) begin
                    errors++;
                    $display("FAIL b2b_accept done=%b busy=%b res=%h want 0 1 %h", done[0], busy[0], obs(0), e1);
                end
                9: if (done[0] !== 1'b1 || obs(0) !== e2) begin
                    errors++;
                    $display("FAIL b2b_second done=%b res=%h want 1 %h", done[0], obs(0), e2);
                end
                default: if (done[0] !== 1'b0) begin
                    errors++;
                    $display("FAIL b2b_stray k=%0d done=%b want 0", k, done[0]);
                end
            endcase
            if (k == 5) start = 1'b0;
        end
        last[0] = e2;
        valid[2:1] = 2'b00;
        drain(20);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        test_reset;
        test_directed;
        test_random;
        test_reset_mid;
        test_ignore_start;
        test_back_to_back;
        run_op(16'h8000, 16'h8000, 1'b0, 1'b0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
